kms_event_arbiter: RTL and testbench

Sits between the NeXT keyboard/mouse serial link block and the host-side monitor-protocol transmitter. It captures each decoded keyboard or mouse packet from the link into its own FIFO and arbitrates the two FIFOs onto one valid/ready event stream. It also schedules LED update commands into the link, rate-limited so that they never arrive faster than one per poll frame.

---
 rtl/kms_event_arbiter.sv | 140 ++++++++++++++
 tb/tb_kms_event_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kms_event_arbiter.sv
// Keyboard/mouse packet capture FIFOs, round-robin event output,
// and rate-limited LED command scheduling for the NeXT link.
module kms_event_arbiter #(
    parameter int KB_DEPTH = 8,
    parameter int MS_DEPTH = 4,
    parameter int LED_GAP  = 60102,
    parameter int GAP_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_avail,
    input  logic        ev_is_mouse,
    input  logic [15:0] ev_data,
    output logic        out_valid,
    output logic        out_is_mouse,
    output logic [15:0] out_data,
    input  logic        out_ready,
    input  logic        led_req,
    input  logic [1:0]  led_val,
    output logic        led_data_valid,
    output logic [1:0]  led_data,
    output logic [7:0]  kb_ovf_cnt,
    output logic [7:0]  ms_ovf_cnt
);
    localparam int KAW = $clog2(KB_DEPTH);
    localparam int MAW = $clog2(MS_DEPTH);
    localparam int KCW = KAW + 1;
    localparam int MCW = MAW + 1;

    typedef enum logic {
        LED_IDLE,
        LED_PEND
    } led_state_t;

    logic           ev_q;
    logic           cap;
    logic [15:0]    kb_mem [KB_DEPTH];
    logic [15:0]    ms_mem [MS_DEPTH];
    logic [KAW-1:0] kb_wp, kb_rp;
    logic [MAW-1:0] ms_wp, ms_rp;
    logic [KCW-1:0] kb_cnt;
    logic [MCW-1:0] ms_cnt;
    logic           kb_ne, ms_ne, kb_full, ms_full;
    logic           load, sel_ms, kb_pop, ms_pop;
    logic           kb_wr, ms_wr, kb_drop, ms_drop;
    logic           rr_ms;

    led_state_t     led_st;
    logic [1:0]     led_lat;
    logic [GAP_W-1:0] gap;
    logic           led_fire;

    assign cap     = ev_avail & ~ev_q;
    assign kb_ne   = kb_cnt != '0;
    assign ms_ne   = ms_cnt != '0;
    assign kb_full = kb_cnt == KCW'(KB_DEPTH);
    assign ms_full = ms_cnt == MCW'(MS_DEPTH);

    assign load   = (~out_valid | out_ready) & (kb_ne | ms_ne);
    assign sel_ms = ms_ne & (~kb_ne | rr_ms);
    assign kb_pop = load & ~sel_ms;
    assign ms_pop = load & sel_ms;

    // A pop in the same cycle frees the slot a full-FIFO capture needs.
    assign kb_wr   = cap & ~ev_is_mouse & (~kb_full | kb_pop);
    assign ms_wr   = cap & ev_is_mouse & (~ms_full | ms_pop);
    assign kb_drop = cap & ~ev_is_mouse & kb_full & ~kb_pop;
    assign ms_drop = cap & ev_is_mouse & ms_full & ~ms_pop;

    always_ff @(posedge clk) begin
        if (kb_wr) kb_mem[kb_wp] <= ev_data;
        if (ms_wr) ms_mem[ms_wp] <= ev_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q         <= 1'b0;
            kb_wp        <= '0;
            kb_rp        <= '0;
            kb_cnt       <= '0;
            ms_wp        <= '0;
            ms_rp        <= '0;
            ms_cnt       <= '0;
            kb_ovf_cnt   <= 8'd0;
            ms_ovf_cnt   <= 8'd0;
            out_valid    <= 1'b0;
            out_is_mouse <= 1'b0;
            out_data     <= 16'd0;
            rr_ms        <= 1'b0;
        end else begin
            ev_q <= ev_avail;
            if (kb_wr) kb_wp <= kb_wp + KAW'(1);
            if (kb_pop) kb_rp <= kb_rp + KAW'(1);
            if (ms_wr) ms_wp <= ms_wp + MAW'(1);
            if (ms_pop) ms_rp <= ms_rp + MAW'(1);
            kb_cnt <= kb_cnt + KCW'(kb_wr) - KCW'(kb_pop);
            ms_cnt <= ms_cnt + MCW'(ms_wr) - MCW'(ms_pop);
            if (kb_drop && kb_ovf_cnt != 8'hFF)
                kb_ovf_cnt <= kb_ovf_cnt + 8'd1;
            if (ms_drop && ms_ovf_cnt != 8'hFF)
                ms_ovf_cnt <= ms_ovf_cnt + 8'd1;
            if (load) begin
                out_valid    <= 1'b1;
                out_is_mouse <= sel_ms;
                out_data     <= sel_ms ? ms_mem[ms_rp] : kb_mem[kb_rp];
                if (kb_ne & ms_ne) rr_ms <= ~rr_ms;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Strobe is decoded from registered state so it lands in the first PENDING cycle.
    assign led_fire       = (led_st == LED_PEND) && (gap == '0);
    assign led_data_valid = led_fire;
    assign led_data       = led_fire ? led_lat : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_st  <= LED_IDLE;
            led_lat <= 2'b00;
            gap     <= '0;
        end else begin
            if (led_fire) gap <= GAP_W'(LED_GAP - 1);
            else if (gap != '0) gap <= gap - GAP_W'(1);
            unique case (led_st)
                LED_IDLE: begin
                    if (led_req) begin
                        led_lat <= led_val;
                        led_st  <= LED_PEND;
                    end
                end
                LED_PEND: begin
                    if (led_req) led_lat <= led_val;
                    else if (led_fire) led_st <= LED_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kms_event_arbiter.sv
// Directed and randomized checks of kms_event_arbiter against a
// queue-based behavioural model.
module tb_kms_event_arbiter;
    localparam int KB_D = 8;
    localparam int MS_D = 4;
    localparam int GAP  = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_avail = 1'b0;
    logic        ev_is_mouse = 1'b0;
    logic [15:0] ev_data = 16'd0;
    logic        out_valid, out_is_mouse;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        led_req = 1'b0;
    logic [1:0]  led_val = 2'b00;
    logic        led_data_valid;
    logic [1:0]  led_data;
    logic [7:0]  kb_ovf_cnt, ms_ovf_cnt;

    kms_event_arbiter #(
        .KB_DEPTH(KB_D),
        .MS_DEPTH(MS_D),
        .LED_GAP (GAP),
        .GAP_W   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ev_avail      (ev_avail),
        .ev_is_mouse   (ev_is_mouse),
        .ev_data       (ev_data),
        .out_valid     (out_valid),
        .out_is_mouse  (out_is_mouse),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .led_req       (led_req),
        .led_val       (led_val),
        .led_data_valid(led_data_valid),
        .led_data      (led_data),
        .kb_ovf_cnt    (kb_ovf_cnt),
        .ms_ovf_cnt    (ms_ovf_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [15:0] kq[$];
    logic [15:0] mq[$];
    bit          m_evq, m_ov, m_om, m_ptr, m_pend, m_had;
    logic [15:0] m_od;
    logic [1:0]  m_lat;
    int          m_kbo, m_mso, m_cyc, m_last;

    logic [15:0] rx[$];
    bit          rxm[$];
    int          st_q[$];
    logic [1:0]  sv_q[$];

    logic [15:0] e4d[5] = '{16'h00F0, 16'h0101, 16'h0201, 16'h0102, 16'h0202};
    bit          e4m[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit led_now();
        return m_pend && (!m_had || (m_cyc - m_last) >= GAP);
    endfunction

    task automatic model_reset();
        kq.delete();
        mq.delete();
        m_evq = 0; m_ov = 0; m_om = 0; m_od = 16'd0; m_ptr = 0;
        m_pend = 0; m_had = 0; m_lat = 2'b00;
        m_kbo = 0; m_mso = 0;
    endtask

    task automatic model_edge();
        bit kne, mne, ld, tk_k, tk_m;
        kne = kq.size() != 0;
        mne = mq.size() != 0;
        ld = (!m_ov || out_ready) && (kne || mne);
        tk_k = 0;
        tk_m = 0;
        if (ld) begin
            if (kne && mne) begin
                tk_k = !m_ptr;
                tk_m = m_ptr;
                m_ptr = !m_ptr;
            end else begin
                tk_k = kne;
                tk_m = mne;
            end
        end
        if (tk_k) begin m_od = kq.pop_front(); m_om = 0; end
        if (tk_m) begin m_od = mq.pop_front(); m_om = 1; end
        if (ld) m_ov = 1;
        else if (out_ready) m_ov = 0;
        if (ev_avail && !m_evq) begin
            if (ev_is_mouse) begin
                if (mq.size() < MS_D) mq.push_back(ev_data);
                else if (m_mso < 255) m_mso++;
            end else begin
                if (kq.size() < KB_D) kq.push_back(ev_data);
                else if (m_kbo < 255) m_kbo++;
            end
        end
        m_evq = ev_avail;
        if (led_now()) begin
            m_last = m_cyc;
            m_had = 1;
            m_pend = 0;
        end
        if (led_req) begin
            m_pend = 1;
            m_lat = led_val;
        end
        m_cyc++;
    endtask

    task automatic check_all();
        bit s;
        s = led_now();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_is_mouse", 32'(out_is_mouse), 32'(m_om));
        end
        chk("kb_ovf_cnt", 32'(kb_ovf_cnt), 32'(m_kbo));
        chk("ms_ovf_cnt", 32'(ms_ovf_cnt), 32'(m_mso));
        chk("led_data_valid", 32'(led_data_valid), 32'(s));
        chk("led_data", 32'(led_data), s ? 32'(m_lat) : 32'd0);
    endtask

    task automatic cycle();
        if (out_valid && out_ready) begin
            rx.push_back(out_data);
            rxm.push_back(out_is_mouse);
        end
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic do_reset();
        ev_avail = 0;
        led_req = 0;
        out_ready = 0;
        rst = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        rst = 0;
    endtask

    task automatic send(bit ms, logic [15:0] d);
        ev_is_mouse = ms;
        ev_data = d;
        ev_avail = 1;
        cycle();
        ev_avail = 0;
        cycle();
    endtask

    initial begin
        int npulse, first, pct;
        m_cyc = 0;
        m_last = 0;

        // reset in the middle of a stream
        do_reset();
        out_ready = 0;
        send(0, 16'h00A1);
        send(0, 16'h00A2);
        send(0, 16'h00A3);
        send(0, 16'h00A4);
        chk("t1_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t1_idle", 32'(out_valid), 32'd0);
        end

        // single held keyboard event
        do_reset();
        out_ready = 1;
        ev_is_mouse = 0;
        ev_data = 16'h1234;
        ev_avail = 1;
        npulse = 0;
        first = -1;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (out_valid) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        ev_avail = 0;
        cycle();
        chk("t2_pulses", 32'(npulse), 32'd1);
        chk("t2_latency", 32'(first), 32'd2);

        // keyboard overflow behind an occupied output register
        do_reset();
        send(0, 16'hBEEF);
        for (int i = 1; i <= 10; i++) send(0, 16'(i));
        chk("t3_kb_ovf", 32'(kb_ovf_cnt), 32'd2);
        rx.delete();
        rxm.delete();
        out_ready = 1;
        repeat (12) cycle();
        chk("t3_rx_count", 32'(rx.size()), 32'd9);
        if (rx.size() == 9) begin
            chk("t3_rx_first", 32'(rx[0]), 32'hBEEF);
            for (int i = 1; i <= 8; i++) chk("t3_rx_order", 32'(rx[i]), 32'(i));
        end

        // round robin with both FIFOs holding two entries
        do_reset();
        send(1, 16'h00F0);
        send(0, 16'h0101);
        send(0, 16'h0102);
        send(1, 16'h0201);
        send(1, 16'h0202);
        rx.delete();
        rxm.delete();
        out_ready = 1;
        repeat (8) cycle();
        chk("t4_rx_count", 32'(rx.size()), 32'd5);
        if (rx.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t4_rr_data", 32'(rx[i]), 32'(e4d[i]));
                chk("t4_rr_type", 32'(rxm[i]), 32'(e4m[i]));
            end
        end

        // backpressure while mouse events arrive
        do_reset();
        send(0, 16'h5555);
        for (int i = 0; i < 50; i++) begin
            ev_is_mouse = 1;
            ev_avail = (i < 8) && (i % 2 == 0);
            ev_data = 16'h0300 + 16'(i / 2);
            cycle();
            chk("t5_hold_data", 32'(out_data), 32'h5555);
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
        end
        ev_avail = 0;
        rx.delete();
        rxm.delete();
        out_ready = 1;
        repeat (8) cycle();
        chk("t5_rx_count", 32'(rx.size()), 32'd5);
        if (rx.size() == 5) begin
            chk("t5_rx0", 32'(rx[0]), 32'h5555);
            for (int i = 1; i < 5; i++) chk("t5_rx_mouse", 32'(rx[i]), 32'h02FF + 32'(i));
        end
        chk("t5_ms_ovf", 32'(ms_ovf_cnt), 32'd0);

        // LED rate limiting
        do_reset();
        st_q.delete();
        sv_q.delete();
        for (int t = 0; t <= GAP + 30; t++) begin
            led_req = (t == 0) || (t == 10) || (t == 20);
            led_val = (t == 0) ? 2'b01 : ((t == 10) ? 2'b10 : 2'b11);
            cycle();
            if (led_data_valid) begin
                st_q.push_back(t + 1);
                sv_q.push_back(led_data);
            end
        end
        led_req = 0;
        chk("t6_strobes", 32'(st_q.size()), 32'd2);
        if (st_q.size() == 2) begin
            chk("t6_t0", 32'(st_q[0]), 32'd1);
            chk("t6_v0", 32'(sv_q[0]), 32'd1);
            chk("t6_t1", 32'(st_q[1]), 32'(1 + GAP));
            chk("t6_v1", 32'(sv_q[1]), 32'd3);
        end

        // overflow counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) send(0, 16'(i));
        chk("t7_kb_sat", 32'(kb_ovf_cnt), 32'd255);

        // randomized traffic against the model
        do_reset();
        pct = 90;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) pct = (n % 1500 == 0) ? 90 : ((n % 1000 == 0) ? 30 : 5);
            if (n == 2000) do_reset();
            ev_avail    = 1'($urandom_range(0, 1));
            ev_is_mouse = 1'($urandom_range(0, 1));
            ev_data     = 16'($urandom);
            out_ready   = $urandom_range(0, 99) < pct;
            led_req     = $urandom_range(0, 149) == 0;
            led_val     = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
